// File: rtl/minirisc_multicycle_ctrl_if.sv
// Control bus between the miniRISC multi-cycle sequencer (master) and the datapath (slave).
// It carries the instruction fields, the memory handshake and every datapath control line.
interface minirisc_multicycle_ctrl_if;
    logic       run;
    logic [5:0] opcode;
    logic [4:0] funct;
    logic       mem_ready;

    logic       PcWrite, IRWrite, RegWrite, ImmSel, ALUSrc, CompEnbl;
    logic       ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg;
    logic [1:0] ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;

    logic [2:0] state_o;
    logic       halted, illegal, bus_err;

    modport master (
        input  run, opcode, funct, mem_ready,
        output PcWrite, IRWrite, RegWrite, ImmSel, ALUSrc, CompEnbl,
               ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg,
               ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
               state_o, halted, illegal, bus_err
    );

    modport slave (
        output run, opcode, funct, mem_ready,
        input  PcWrite, IRWrite, RegWrite, ImmSel, ALUSrc, CompEnbl,
               ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg,
               ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
               state_o, halted, illegal, bus_err
    );
endinterface

// File: rtl/minirisc_multicycle_ctrl.sv
// Multi-cycle control sequencer for the KGP miniRISC datapath: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives all datapath control lines.
module minirisc_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    minirisc_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_COMPI = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h03;
    localparam logic [5:0] OP_SW    = 6'h04;
    localparam logic [5:0] OP_BR    = 6'h05;
    localparam logic [5:0] OP_BLTZ  = 6'h06;
    localparam logic [5:0] OP_BZ    = 6'h07;
    localparam logic [5:0] OP_BNZ   = 6'h08;
    localparam logic [5:0] OP_B     = 6'h09;
    localparam logic [5:0] OP_BL    = 6'h0A;
    localparam logic [5:0] OP_BCY   = 6'h0B;
    localparam logic [5:0] OP_BNCY  = 6'h0C;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Last MEM cycle index (counter starts at 0 on MEM entry) before the abort.
    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [5:0] op_q;
    logic [4:0] fn_q;
    logic [3:0] tmo_cnt, tmo_nx;
    logic       bus_err_q, set_err;
    logic       ctl_en;

    logic       d_imm, d_alusrc, d_comp, d_sas, d_se, d_sbr, d_lbr, d_breg;
    logic [1:0] d_aluop, d_rd, d_st, d_bt, d_jt, d_m2r;

    function automatic logic is_legal(input logic [5:0] op, input logic [4:0] fn);
        if (op == OP_RTYPE) return fn <= 5'd9;
        return op <= OP_BNCY;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            fn_q      <= '0;
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_nx;
            if (state == DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
            if (set_err) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        tmo_nx       = '0;
        set_err      = 1'b0;
        bus.PcWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            IDLE: if (bus.run) state_nx = FETCH;
            FETCH: begin
                bus.IRWrite = 1'b1;
                state_nx    = DECODE;
            end
            // Legality is judged on the live instruction fields; they are latched on this edge.
            DECODE: begin
                if (bus.opcode == OP_HALT) begin
                    state_nx = HALT;
                end else if (!is_legal(bus.opcode, bus.funct)) begin
                    bus.illegal = 1'b1;
                    bus.PcWrite = 1'b1;
                    state_nx    = FETCH;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI, OP_COMPI, OP_BL: state_nx = WB;
                    OP_LW, OP_SW:                       state_nx = MEM;
                    default: begin
                        bus.PcWrite = 1'b1;
                        state_nx    = FETCH;
                    end
                endcase
            end
            MEM: begin
                bus.MemRead  = (op_q == OP_LW);
                bus.MemWrite = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_SW) begin
                        bus.PcWrite = 1'b1;
                        state_nx    = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    set_err     = 1'b1;
                    bus.PcWrite = 1'b1;
                    state_nx    = FETCH;
                end else begin
                    tmo_nx = tmo_cnt + 4'd1;
                end
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.PcWrite  = 1'b1;
                state_nx     = FETCH;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        d_imm    = 1'b0;
        d_alusrc = 1'b0;
        d_comp   = 1'b0;
        d_sas    = 1'b0;
        d_se     = 1'b0;
        d_sbr    = 1'b0;
        d_lbr    = 1'b0;
        d_breg   = 1'b0;
        d_aluop  = '0;
        d_rd     = '0;
        d_st     = '0;
        d_bt     = '0;
        d_jt     = '0;
        d_m2r    = '0;
        case (op_q)
            OP_RTYPE: begin
                case (fn_q)
                    5'd0: d_aluop = 2'b01;
                    5'd1: begin d_aluop = 2'b01; d_comp = 1'b1; end
                    5'd2: d_aluop = 2'b10;
                    5'd3: d_aluop = 2'b11;
                    5'd4: d_se = 1'b1;
                    5'd5: begin d_se = 1'b1; d_st = 2'b01; end
                    5'd6: begin d_se = 1'b1; d_sas = 1'b1; end
                    5'd7: begin d_se = 1'b1; d_sas = 1'b1; d_st = 2'b01; end
                    5'd8: begin d_se = 1'b1; d_st = 2'b10; end
                    5'd9: begin d_se = 1'b1; d_sas = 1'b1; d_st = 2'b10; end
                    default: ;
                endcase
            end
            OP_ADDI:  begin d_alusrc = 1'b1; d_aluop = 2'b01; end
            OP_COMPI: begin d_alusrc = 1'b1; d_aluop = 2'b01; d_comp = 1'b1; end
            OP_LW:    begin d_alusrc = 1'b1; d_aluop = 2'b01; d_m2r = 2'b01; end
            OP_SW:    begin d_alusrc = 1'b1; d_aluop = 2'b01; end
            OP_BR:    d_breg = 1'b1;
            OP_BLTZ:  d_sbr = 1'b1;
            OP_BZ:    begin d_sbr = 1'b1; d_bt = 2'b01; end
            OP_BNZ:   begin d_sbr = 1'b1; d_bt = 2'b10; end
            OP_B:     begin d_lbr = 1'b1; d_imm = 1'b1; end
            OP_BL:    begin d_lbr = 1'b1; d_imm = 1'b1; d_rd = 2'b10; d_m2r = 2'b10; end
            OP_BCY:   begin d_sbr = 1'b1; d_lbr = 1'b1; d_imm = 1'b1; d_bt = 2'b11; d_jt = 2'b10; end
            OP_BNCY:  begin d_sbr = 1'b1; d_lbr = 1'b1; d_imm = 1'b1; d_bt = 2'b11; d_jt = 2'b11; end
            default: ;
        endcase
    end

    // Decoded controls stay valid from EXEC through WB so the datapath sees them at PcWrite/RegWrite.
    assign ctl_en           = (state == EXEC) || (state == MEM) || (state == WB);
    assign bus.ImmSel       = ctl_en & d_imm;
    assign bus.ALUSrc       = ctl_en & d_alusrc;
    assign bus.CompEnbl     = ctl_en & d_comp;
    assign bus.ShiftAmntSel = ctl_en & d_sas;
    assign bus.ShiftEnbl    = ctl_en & d_se;
    assign bus.ShortBr      = ctl_en & d_sbr;
    assign bus.LongBr       = ctl_en & d_lbr;
    assign bus.BranchReg    = ctl_en & d_breg;
    assign bus.ALUOp        = ctl_en ? d_aluop : '0;
    assign bus.RegDst       = ctl_en ? d_rd    : '0;
    assign bus.ShiftType    = ctl_en ? d_st    : '0;
    assign bus.BranchType   = ctl_en ? d_bt    : '0;
    assign bus.JumpType     = ctl_en ? d_jt    : '0;
    assign bus.MemToReg     = ctl_en ? d_m2r   : '0;

    assign bus.state_o = state;
    assign bus.halted  = (state == HALT);
    assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_minirisc_multicycle_ctrl.sv
// Bench for minirisc_multicycle_ctrl: a decode table of instructions plus randomized instruction
// streams, each expanded cycle by cycle into expected outputs by a per-instruction phase model.
module tb_minirisc_multicycle_ctrl;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    minirisc_multicycle_ctrl_if bus();

    minirisc_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, BranchReg;
        logic [1:0] ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    } ctl_t;

    typedef struct packed {
        logic [2:0] state;
        logic       PcWrite, IRWrite, RegWrite, MemRead, MemWrite, halted, illegal, bus_err;
        ctl_t       ctl;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [4:0] fn;
        int         ready_at;
        ctl_t       ctl;
        int         cycles;
        string      nm;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic err_m = 1'b0;
    logic noise = 1'b0;
    logic run_noise = 1'b0;

    // flags = {ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, BranchReg}
    function automatic ctl_t c(input logic [7:0] flags, input logic [1:0] aluop, rd, st, bt, jt, m2r);
        ctl_t r;
        {r.ImmSel, r.ALUSrc, r.CompEnbl, r.ShiftAmntSel,
         r.ShiftEnbl, r.ShortBr, r.LongBr, r.BranchReg} = flags;
        r.ALUOp = aluop; r.RegDst = rd; r.ShiftType = st;
        r.BranchType = bt; r.JumpType = jt; r.MemToReg = m2r;
        return r;
    endfunction

    task automatic add_vec(input logic [5:0] op, input logic [4:0] fn, input int ra,
                           input ctl_t ct, input int cy, input string nm);
        vec_t v;
        v.op = op; v.fn = fn; v.ready_at = ra; v.ctl = ct; v.cycles = cy; v.nm = nm;
        vt.push_back(v);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.state = bus.state_o;
        o.PcWrite = bus.PcWrite; o.IRWrite = bus.IRWrite; o.RegWrite = bus.RegWrite;
        o.MemRead = bus.MemRead; o.MemWrite = bus.MemWrite;
        o.halted = bus.halted; o.illegal = bus.illegal; o.bus_err = bus.bus_err;
        o.ctl.ImmSel = bus.ImmSel; o.ctl.ALUSrc = bus.ALUSrc; o.ctl.CompEnbl = bus.CompEnbl;
        o.ctl.ShiftAmntSel = bus.ShiftAmntSel; o.ctl.ShiftEnbl = bus.ShiftEnbl;
        o.ctl.ShortBr = bus.ShortBr; o.ctl.LongBr = bus.LongBr; o.ctl.BranchReg = bus.BranchReg;
        o.ctl.ALUOp = bus.ALUOp; o.ctl.RegDst = bus.RegDst; o.ctl.ShiftType = bus.ShiftType;
        o.ctl.BranchType = bus.BranchType; o.ctl.JumpType = bus.JumpType; o.ctl.MemToReg = bus.MemToReg;
        return o;
    endfunction

    function automatic obs_t base();
        obs_t o;
        o = '0;
        o.bus_err = err_m;
        return o;
    endfunction

    function automatic logic nz();
        return noise ? 1'($urandom) : 1'b0;
    endfunction

    function automatic logic m_legal(input logic [5:0] op, input logic [4:0] fn);
        if (op == 6'd0) return fn < 5'd10;
        return (op >= 6'd1) && (op <= 6'd12);
    endfunction

    function automatic logic m_branch(input logic [5:0] op);
        return (op >= 6'd5) && (op <= 6'd12) && (op != 6'd10);
    endfunction

    task automatic check(input string nm, input obs_t exp);
        obs_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive this cycle's inputs, compare mid-cycle, advance.
    task automatic cycle(input obs_t e, input logic mr, input string nm);
        bus.mem_ready = mr;
        if (run_noise) bus.run = 1'($urandom);
        @(negedge clk);
        check(nm, e);
        @(posedge clk);
        #1;
    endtask

    // Phase model of one instruction starting in FETCH; returns its length in cycles.
    task automatic run_instr(input logic [5:0] op, input logic [4:0] fn, input int ready_at,
                             input int abort_k, input ctl_t ctl, input string nm, output int ncyc);
        obs_t e;
        logic rdy;
        ncyc = 0;
        bus.opcode = op;
        bus.funct  = fn;
        e = base(); e.state = 3'd1; e.IRWrite = 1'b1;
        cycle(e, nz(), {nm, ":fetch"}); ncyc++;
        e = base(); e.state = 3'd2;
        if (op == 6'h3F) begin
            cycle(e, nz(), {nm, ":decode"}); ncyc++;
            return;
        end
        if (!m_legal(op, fn)) begin
            e.illegal = 1'b1; e.PcWrite = 1'b1;
            cycle(e, nz(), {nm, ":decode"}); ncyc++;
            return;
        end
        cycle(e, nz(), {nm, ":decode"}); ncyc++;
        e = base(); e.state = 3'd3; e.ctl = ctl;
        e.PcWrite = m_branch(op);
        cycle(e, nz(), {nm, ":exec"}); ncyc++;
        if (m_branch(op)) return;
        if (op == 6'd3 || op == 6'd4) begin
            for (int k = 0; k < TMO; k++) begin
                if (k == abort_k) begin
                    bus.mem_ready = 1'b0;
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    err_m = 1'b0;
                    check({nm, ":reset"}, base());
                    return;
                end
                rdy = (k == ready_at);
                e = base(); e.state = 3'd4; e.ctl = ctl;
                e.MemRead = (op == 6'd3); e.MemWrite = (op == 6'd4);
                e.PcWrite = rdy ? (op == 6'd4) : (k == TMO - 1);
                cycle(e, rdy, $sformatf("%s:mem%0d", nm, k)); ncyc++;
                if (!rdy && k == TMO - 1) begin
                    err_m = 1'b1;
                    return;
                end
                if (rdy) begin
                    if (op == 6'd4) return;
                    break;
                end
            end
        end
        e = base(); e.state = 3'd5; e.ctl = ctl; e.RegWrite = 1'b1; e.PcWrite = 1'b1;
        cycle(e, nz(), {nm, ":wb"}); ncyc++;
    endtask

    initial begin
        int         n;
        int         idx;
        int         ra;
        logic [5:0] op;
        logic [4:0] fn;
        ctl_t       ct;
        obs_t       e;
        ctl_t       c_lw, c_sw, c_addi;

        c_addi = c(8'b0100_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        c_lw   = c(8'b0100_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1);
        c_sw   = c(8'b0100_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add_vec(6'h01, 5'd0,  0, c_addi, 4, "addi");
        add_vec(6'h00, 5'd0,  0, c(8'b0000_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "add");
        add_vec(6'h00, 5'd1,  0, c(8'b0010_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "comp");
        add_vec(6'h00, 5'd2,  0, c(8'b0000_0000, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "and");
        add_vec(6'h00, 5'd3,  0, c(8'b0000_0000, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "xor");
        add_vec(6'h00, 5'd4,  0, c(8'b0000_1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "shll");
        add_vec(6'h00, 5'd5,  0, c(8'b0000_1000, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0), 4, "shrl");
        add_vec(6'h00, 5'd6,  0, c(8'b0001_1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "shllv");
        add_vec(6'h00, 5'd7,  0, c(8'b0001_1000, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0), 4, "shrlv");
        add_vec(6'h00, 5'd8,  0, c(8'b0000_1000, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0), 4, "shra");
        add_vec(6'h00, 5'd9,  0, c(8'b0001_1000, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0), 4, "shrav");
        add_vec(6'h02, 5'd0,  0, c(8'b0110_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 4, "compi");
        add_vec(6'h03, 5'd0,  0, c_lw, 5, "lw");
        add_vec(6'h04, 5'd0,  1, c_sw, 5, "sw");
        add_vec(6'h05, 5'd0,  0, c(8'b0000_0001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 3, "br");
        add_vec(6'h06, 5'd0,  0, c(8'b0000_0100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 3, "bltz");
        add_vec(6'h07, 5'd0,  0, c(8'b0000_0100, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0), 3, "bz");
        add_vec(6'h08, 5'd0,  0, c(8'b0000_0100, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0), 3, "bnz");
        add_vec(6'h09, 5'd0,  0, c(8'b1000_0010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 3, "b");
        add_vec(6'h0A, 5'd0,  0, c(8'b1000_0010, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2), 4, "bl");
        add_vec(6'h0B, 5'd0,  0, c(8'b1000_0110, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0), 3, "bcy");
        add_vec(6'h0C, 5'd0,  0, c(8'b1000_0110, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0), 3, "bncy");
        add_vec(6'h00, 5'd31, 0, '0, 2, "ill_f31");
        add_vec(6'h00, 5'd10, 0, '0, 2, "ill_f10");
        add_vec(6'h0D, 5'd0,  0, '0, 2, "ill_op0d");
        add_vec(6'h3E, 5'd5,  0, '0, 2, "ill_op3e");

        rst = 1'b0;
        bus.run = 1'b0; bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", base());
        rst = 1'b1;
        bus.run = 1'b1;
        cycle(base(), 1'b0, "idle_run");
        run_noise = 1'b1;

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].ready_at, -1, vt[i].ctl, vt[i].nm, n);
            check_int({vt[i].nm, ":len"}, n, vt[i].cycles);
        end

        noise = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(13, 62));
                fn = 5'($urandom);
                ct = '0;
            end else begin
                idx = int'($urandom_range(0, vt.size() - 1));
                op  = vt[idx].op;
                fn  = (op == 6'd0) ? vt[idx].fn : 5'($urandom);
                ct  = vt[idx].ctl;
            end
            ra = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            run_instr(op, fn, ra, -1, ct, $sformatf("rnd%0d", t), n);
        end
        noise = 1'b0;

        run_instr(6'h04, 5'd0, -1, -1, c_sw, "sw_tmo", n);
        check_int("sw_tmo:len", n, 3 + TMO);
        check_int("sw_tmo:sticky", int'(bus.bus_err), 1);
        run_instr(6'h01, 5'd0, 0, -1, c_addi, "addi_after_err", n);
        run_instr(6'h03, 5'd0, 2, -1, c_lw, "lw_wait", n);
        check_int("lw_wait:len", n, 7);
        run_instr(6'h04, 5'd0, TMO - 1, -1, c_sw, "sw_last", n);
        check_int("sw_last:len", n, 3 + TMO);

        run_instr(6'h03, 5'd0, -1, 2, c_lw, "lw_rst", n);
        run_noise = 1'b0;
        bus.run = 1'b0;
        rst = 1'b1;
        cycle(base(), 1'b0, "idle_hold0");
        cycle(base(), 1'b1, "idle_hold1");
        bus.run = 1'b1;
        cycle(base(), 1'b0, "idle_go");
        run_noise = 1'b1;
        run_instr(6'h01, 5'd0, 0, -1, c_addi, "addi_restart", n);
        check_int("addi_restart:len", n, 4);

        run_instr(6'h3F, 5'd0, 0, -1, '0, "halt", n);
        for (int k = 0; k < 6; k++) begin
            bus.opcode = 6'($urandom);
            bus.funct  = 5'($urandom);
            e = base(); e.state = 3'd6; e.halted = 1'b1;
            cycle(e, 1'($urandom), $sformatf("halted%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
